// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control FSM for the MIPS-subset datapath,
// including ALU operation decode and a timed memory ready handshake.
`default_nettype none

module controle_multiciclo #(
  parameter int MAX_ESPERA = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_pronto,
  output logic       pc_escreve,
  output logic       pc_escreve_cond,
  output logic [1:0] pc_fonte,
  output logic       i_ou_d,
  output logic       mem_le,
  output logic       mem_escreve,
  output logic       ir_escreve,
  output logic       reg_dst,
  output logic       mem_para_reg,
  output logic       reg_escreve,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] saida_alu_control,
  output logic [3:0] estado,
  output logic       instr_invalida
);

  typedef enum logic [3:0] {
    BUSCA           = 4'd0,
    DECODIFICA      = 4'd1,
    END_MEM         = 4'd2,
    LE_MEM          = 4'd3,
    ESCREVE_REG_MEM = 4'd4,
    ESCREVE_MEM     = 4'd5,
    EXECUTA         = 4'd6,
    ESCREVE_REG_R   = 4'd7,
    DESVIO          = 4'd8,
    SALTO           = 4'd9,
    EXEC_ADDI       = 4'd10,
    ESCREVE_REG_I   = 4'd11,
    INVALIDA        = 4'd12
  } estado_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  estado_t    state;
  estado_t    next_state;
  logic [7:0] espera;
  logic [8:0] espera_inc;
  logic       eh_lw;
  logic       aguardando;
  logic       timeout;
  logic       funct_ok;
  logic [3:0] alu_funct;
  logic       unused_zero;

  // The zero flag gates the PC in the datapath, not here.
  assign unused_zero = zero;

  always_comb begin
    funct_ok  = 1'b1;
    alu_funct = ALU_ADD;
    case (funct)
      FN_ADD:  alu_funct = ALU_ADD;
      FN_SUB:  alu_funct = ALU_SUB;
      FN_AND:  alu_funct = ALU_AND;
      FN_OR:   alu_funct = ALU_OR;
      FN_SLT:  alu_funct = ALU_SLT;
      FN_NOR:  alu_funct = ALU_NOR;
      default: funct_ok  = 1'b0;
    endcase
  end

  assign aguardando = (state == BUSCA) || (state == LE_MEM) || (state == ESCREVE_MEM);
  assign espera_inc = {1'b0, espera} + 9'd1;
  // A ready arriving on the last allowed cycle still completes the access.
  assign timeout    = aguardando && !mem_pronto && (espera_inc >= 9'(MAX_ESPERA));

  always_comb begin
    next_state = state;
    case (state)
      BUSCA: begin
        if (mem_pronto)   next_state = DECODIFICA;
        else if (timeout) next_state = INVALIDA;
      end
      DECODIFICA: begin
        case (opcode)
          OP_LW, OP_SW: next_state = END_MEM;
          OP_RTYPE:     next_state = funct_ok ? EXECUTA : INVALIDA;
          OP_BEQ:       next_state = DESVIO;
          OP_J:         next_state = SALTO;
          OP_ADDI:      next_state = EXEC_ADDI;
          default:      next_state = INVALIDA;
        endcase
      end
      END_MEM:         next_state = eh_lw ? LE_MEM : ESCREVE_MEM;
      LE_MEM: begin
        if (mem_pronto)   next_state = ESCREVE_REG_MEM;
        else if (timeout) next_state = INVALIDA;
      end
      ESCREVE_REG_MEM: next_state = BUSCA;
      ESCREVE_MEM: begin
        if (mem_pronto)   next_state = BUSCA;
        else if (timeout) next_state = INVALIDA;
      end
      EXECUTA:         next_state = ESCREVE_REG_R;
      ESCREVE_REG_R:   next_state = BUSCA;
      DESVIO:          next_state = BUSCA;
      SALTO:           next_state = BUSCA;
      EXEC_ADDI:       next_state = ESCREVE_REG_I;
      ESCREVE_REG_I:   next_state = BUSCA;
      INVALIDA:        next_state = INVALIDA;
      default:         next_state = INVALIDA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= BUSCA;
      espera <= '0;
      eh_lw  <= 1'b0;
    end else begin
      state <= next_state;
      if (aguardando && !mem_pronto && !timeout) espera <= espera_inc[7:0];
      else                                       espera <= '0;
      // lw/sw is remembered so END_MEM does not depend on the opcode bus.
      if (state == DECODIFICA) eh_lw <= (opcode == OP_LW);
    end
  end

  always_comb begin
    pc_escreve        = 1'b0;
    pc_escreve_cond   = 1'b0;
    pc_fonte          = 2'b00;
    i_ou_d            = 1'b0;
    mem_le            = 1'b0;
    mem_escreve       = 1'b0;
    ir_escreve        = 1'b0;
    reg_dst           = 1'b0;
    mem_para_reg      = 1'b0;
    reg_escreve       = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    saida_alu_control = ALU_ADD;
    estado            = state;
    instr_invalida    = 1'b0;
    case (state)
      BUSCA: begin
        mem_le     = 1'b1;
        alu_src_b  = 2'b01;
        ir_escreve = mem_pronto;
        pc_escreve = mem_pronto;
      end
      DECODIFICA:  alu_src_b = 2'b11;
      END_MEM: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      LE_MEM: begin
        mem_le = 1'b1;
        i_ou_d = 1'b1;
      end
      ESCREVE_REG_MEM: begin
        reg_escreve  = 1'b1;
        mem_para_reg = 1'b1;
      end
      ESCREVE_MEM: begin
        mem_escreve = 1'b1;
        i_ou_d      = 1'b1;
      end
      EXECUTA: begin
        alu_src_a         = 1'b1;
        saida_alu_control = alu_funct;
      end
      ESCREVE_REG_R: begin
        reg_escreve = 1'b1;
        reg_dst     = 1'b1;
      end
      DESVIO: begin
        alu_src_a         = 1'b1;
        saida_alu_control = ALU_SUB;
        pc_escreve_cond   = 1'b1;
        pc_fonte          = 2'b01;
      end
      SALTO: begin
        pc_escreve = 1'b1;
        pc_fonte   = 2'b10;
      end
      EXEC_ADDI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ESCREVE_REG_I:   reg_escreve = 1'b1;
      INVALIDA:        instr_invalida = 1'b1;
      default:         instr_invalida = 1'b1;
    endcase
    // Reset silences every strobe immediately, aborting any pending access.
    if (!reset_n) begin
      pc_escreve        = 1'b0;
      pc_escreve_cond   = 1'b0;
      pc_fonte          = 2'b00;
      i_ou_d            = 1'b0;
      mem_le            = 1'b0;
      mem_escreve       = 1'b0;
      ir_escreve        = 1'b0;
      reg_dst           = 1'b0;
      mem_para_reg      = 1'b0;
      reg_escreve       = 1'b0;
      alu_src_a         = 1'b0;
      alu_src_b         = 2'b00;
      saida_alu_control = 4'b0000;
      estado            = 4'b0000;
      instr_invalida    = 1'b0;
    end
  end

endmodule

`default_nettype wire
